// File: rtl/sar_pkg.sv
// Shared types and default constants for the SAR ADC controller.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRACK_S = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } sar_state_e;

  localparam int unsigned DEF_N_BITS   = 8;
  localparam int unsigned DEF_TRACK    = 2;
  localparam int unsigned DEF_SETTLE   = 2;
  // Width in clk_in cycles of the strobe produced by the sample divider.
  localparam int unsigned TICK_PULSE_W = 1;

endpackage

// File: rtl/sar_controller.sv
// Successive-approximation controller: track, binary search MSB->LSB, publish result.
module sar_controller
  import sar_pkg::*;
#(
  parameter int unsigned N_BITS = DEF_N_BITS,
  parameter int unsigned TRACK  = DEF_TRACK,
  parameter int unsigned SETTLE = DEF_SETTLE
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic              comp_in,
  output logic [N_BITS-1:0] dac_code,
  output logic              sample_hold,
  output logic              busy,
  output logic [N_BITS-1:0] data_out,
  output logic              data_valid,
  output logic              overrun
);

  localparam int unsigned TrackW  = $clog2(TRACK + 1);
  localparam int unsigned SettleW = $clog2(SETTLE + 1);
  localparam int unsigned IdxW    = $clog2(N_BITS);

  localparam logic [TrackW-1:0]  TrackLast  = TrackW'(TRACK - 1);
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE - 1);
  localparam logic [IdxW-1:0]    IdxMsb     = IdxW'(N_BITS - 1);
  localparam logic [N_BITS-1:0]  One        = N_BITS'(1);

  sar_state_e          state_q, state_d;
  logic [TrackW-1:0]   track_cnt_q, track_cnt_d;
  logic [SettleW-1:0]  settle_cnt_q, settle_cnt_d;
  logic [IdxW-1:0]     bit_idx_q, bit_idx_d;
  logic [N_BITS-1:0]   result_q, result_d;
  logic [N_BITS-1:0]   data_out_q, data_out_d;
  logic                overrun_q, overrun_d;
  logic [N_BITS-1:0]   bit_mask;
  logic [N_BITS-1:0]   decided;

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      track_cnt_q  <= '0;
      settle_cnt_q <= '0;
      bit_idx_q    <= '0;
      result_q     <= '0;
      data_out_q   <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      track_cnt_q  <= track_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      bit_idx_q    <= bit_idx_d;
      result_q     <= result_d;
      data_out_q   <= data_out_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next-state logic and Moore outputs.
  always_comb begin
    state_d      = state_q;
    track_cnt_d  = track_cnt_q;
    settle_cnt_d = settle_cnt_q;
    bit_idx_d    = bit_idx_q;
    result_d     = result_q;
    data_out_d   = data_out_q;
    overrun_d    = 1'b0;
    dac_code     = '0;
    sample_hold  = 1'b0;
    busy         = 1'b0;
    data_valid   = 1'b0;
    bit_mask     = One << bit_idx_q;
    // Result with the current bit resolved by the comparator.
    decided      = comp_in ? (result_q | bit_mask) : (result_q & ~bit_mask);

    unique case (state_q)
      IDLE: begin
        if (sample_tick) begin
          state_d     = TRACK_S;
          track_cnt_d = '0;
        end
      end
      TRACK_S: begin
        sample_hold = 1'b1;
        busy        = 1'b1;
        overrun_d   = sample_tick;
        if (track_cnt_q == TrackLast) begin
          state_d      = CONVERT;
          bit_idx_d    = IdxMsb;
          result_d     = '0;
          settle_cnt_d = '0;
        end else begin
          track_cnt_d = track_cnt_q + 1'b1;
        end
      end
      CONVERT: begin
        busy      = 1'b1;
        dac_code  = result_q | bit_mask;
        overrun_d = sample_tick;
        if (settle_cnt_q == SettleLast) begin
          settle_cnt_d = '0;
          result_d     = decided;
          if (bit_idx_q == '0) begin
            state_d    = DONE;
            data_out_d = decided;
          end else begin
            bit_idx_d = bit_idx_q - 1'b1;
          end
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      DONE: begin
        busy       = 1'b1;
        data_valid = 1'b1;
        dac_code   = result_q;
        // A tick landing on the publish cycle chains straight into the next sample.
        if (sample_tick) begin
          state_d     = TRACK_S;
          track_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_out = data_out_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_sar_controller.sv
// Self-checking bench for sar_controller with an ideal comparator model.
module tb_sar_controller;
  import sar_pkg::*;

  logic clk_in = 1'b0;
  logic rst    = 1'b0;
  always #5 clk_in = ~clk_in;

  // Default-parameter instance
  logic       tick_a = 1'b0;
  logic       comp_a;
  logic [7:0] vin_a  = '0;
  int         mode_a = 0;  // 0 ideal comparator, 1 tied high, 2 tied low
  logic [7:0] dac_a, dout_a;
  logic       sh_a, busy_a, dv_a, ovr_a;

  // Reduced instance for the parameter sweep
  logic       tick_b = 1'b0;
  logic       comp_b;
  logic [3:0] vin_b  = '0;
  logic [3:0] dac_b, dout_b;
  logic       sh_b, busy_b, dv_b, ovr_b;

  assign comp_a = (mode_a == 1) ? 1'b1 : (mode_a == 2) ? 1'b0 : (vin_a >= dac_a);
  assign comp_b = (vin_b >= dac_b);

  sar_controller u_dut_a (
    .clk_in     (clk_in),
    .rst        (rst),
    .sample_tick(tick_a),
    .comp_in    (comp_a),
    .dac_code   (dac_a),
    .sample_hold(sh_a),
    .busy       (busy_a),
    .data_out   (dout_a),
    .data_valid (dv_a),
    .overrun    (ovr_a)
  );

  sar_controller #(
    .N_BITS(4),
    .TRACK (1),
    .SETTLE(1)
  ) u_dut_b (
    .clk_in     (clk_in),
    .rst        (rst),
    .sample_tick(tick_b),
    .comp_in    (comp_b),
    .dac_code   (dac_b),
    .sample_hold(sh_b),
    .busy       (busy_b),
    .data_out   (dout_b),
    .data_valid (dv_b),
    .overrun    (ovr_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Latency from tick-setup cycle to data_valid cycle, from the documented timing.
  localparam int LatA = DEF_TRACK + DEF_N_BITS * DEF_SETTLE + 1;
  localparam int LatB = 1 + 4 * 1 + 1;

  int          tick_at[$];
  int          dv_cyc[$];
  int          ovr_cyc[$];
  logic [15:0] dout_at_dv[$];
  logic [15:0] cap[$];
  logic [15:0] exp_q[$];
  logic        busy_hist[$];

  // Ideal binary search: list of trial codes (each repeated per settle cycle) and final code.
  task automatic sar_ref(input int nb, input int st, input int v, input int md, output int res);
    int trial;
    bit up;
    exp_q.delete();
    res = 0;
    for (int i = nb - 1; i >= 0; i--) begin
      trial = res + (1 << i);
      for (int s = 0; s < st; s++) exp_q.push_back(16'(trial));
      up = (md == 1) ? 1'b1 : (md == 2) ? 1'b0 : (v >= trial);
      if (up) res = trial;
    end
  endtask

  // Runs n sample cycles on instance A; cycle c asserts tick if c is in tick_at.
  task automatic run_a(input int n);
    dv_cyc.delete(); ovr_cyc.delete(); dout_at_dv.delete(); cap.delete(); busy_hist.delete();
    for (int c = 0; c < n; c++) begin
      @(negedge clk_in);
      if (dv_a) begin
        dv_cyc.push_back(c);
        dout_at_dv.push_back(16'(dout_a));
      end
      if (ovr_a) ovr_cyc.push_back(c);
      if (busy_a && !sh_a && !dv_a) cap.push_back(16'(dac_a));
      busy_hist.push_back(busy_a);
      tick_a = 1'b0;
      foreach (tick_at[j]) if (tick_at[j] == c) tick_a = 1'b1;
    end
    tick_a = 1'b0;
  endtask

  task automatic run_b(input int n);
    dv_cyc.delete(); ovr_cyc.delete(); dout_at_dv.delete(); cap.delete(); busy_hist.delete();
    for (int c = 0; c < n; c++) begin
      @(negedge clk_in);
      if (dv_b) begin
        dv_cyc.push_back(c);
        dout_at_dv.push_back(16'(dout_b));
      end
      if (ovr_b) ovr_cyc.push_back(c);
      if (busy_b && !sh_b && !dv_b) cap.push_back(16'(dac_b));
      busy_hist.push_back(busy_b);
      tick_b = 1'b0;
      foreach (tick_at[j]) if (tick_at[j] == c) tick_b = 1'b1;
    end
    tick_b = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk_in);
    n_checks++;
    if ({dac_a, sh_a, busy_a, dout_a, dv_a, ovr_a} !== 20'h0) begin
      n_errors++;
      $display("FAIL reset_a: outputs %h, expected 0", {dac_a, sh_a, busy_a, dout_a, dv_a, ovr_a});
    end
    n_checks++;
    if ({dac_b, sh_b, busy_b, dout_b, dv_b, ovr_b} !== 12'h0) begin
      n_errors++;
      $display("FAIL reset_b: outputs %h, expected 0", {dac_b, sh_b, busy_b, dout_b, dv_b, ovr_b});
    end
    rst = 1'b0;
    @(negedge clk_in);
  endtask

  // One conversion on A with comparator mode md, checking latency, trials, result, busy.
  task automatic check_single(input string nm, input int v, input int md);
    int res;
    int bad;
    vin_a  = 8'(v);
    mode_a = md;
    sar_ref(8, DEF_SETTLE, v, md, res);
    tick_at = '{0};
    run_a(LatA + 4);
    n_checks++;
    if (dv_cyc.size() != 1 || dv_cyc[0] != LatA) begin
      n_errors++;
      $display("FAIL %s latency: dv pulses %0d first at %0d, expected 1 at %0d",
               nm, dv_cyc.size(), (dv_cyc.size() > 0) ? dv_cyc[0] : -1, LatA);
    end
    n_checks++;
    if (dout_at_dv.size() < 1 || dout_at_dv[0] !== 16'(res)) begin
      n_errors++;
      $display("FAIL %s data_out: got %h expected %h", nm,
               (dout_at_dv.size() > 0) ? dout_at_dv[0] : 16'hxxxx, res);
    end
    bad = -1;
    if (cap.size() == exp_q.size())
      for (int i = cap.size() - 1; i >= 0; i--) if (cap[i] !== exp_q[i]) bad = i;
    n_checks++;
    if (cap.size() != exp_q.size() || bad >= 0) begin
      n_errors++;
      $display("FAIL %s trials: %0d codes, first bad idx %0d got %h expected %h (of %0d)", nm,
               cap.size(), bad, (bad >= 0) ? cap[bad] : 16'h0, (bad >= 0) ? exp_q[bad] : 16'h0,
               exp_q.size());
    end
    n_checks++;
    if (busy_hist[1] !== 1'b1 || busy_hist[LatA + 1] !== 1'b0) begin
      n_errors++;
      $display("FAIL %s busy: first %b after_dv %b, expected 1 and 0", nm,
               busy_hist[1], busy_hist[LatA + 1]);
    end
  endtask

  task automatic test_conversion();
    check_single("vin_a5", 'hA5, 0);
    check_single("tied1", 0, 1);
    check_single("tied0", 'hFF, 2);
    for (int k = 0; k < 4; k++) check_single("random", int'($urandom_range(0, 255)), 0);
  endtask

  task automatic test_overrun();
    vin_a   = 8'hA5;
    mode_a  = 0;
    tick_at = '{0, 8};
    run_a(40);
    n_checks++;
    if (ovr_cyc.size() != 1 || ovr_cyc[0] != 9) begin
      n_errors++;
      $display("FAIL overrun_pulse: %0d pulses first at %0d, expected 1 at 9", ovr_cyc.size(),
               (ovr_cyc.size() > 0) ? ovr_cyc[0] : -1);
    end
    n_checks++;
    if (dv_cyc.size() != 1 || dout_at_dv[0] !== 16'hA5 || dv_cyc[0] != LatA) begin
      n_errors++;
      $display("FAIL overrun_result: %0d dv, data %h, expected 1 dv of a5 at %0d",
               dv_cyc.size(), (dout_at_dv.size() > 0) ? dout_at_dv[0] : 16'h0, LatA);
    end
    n_checks++;
    if (busy_hist[LatA + 1] !== 1'b0 || busy_hist[39] !== 1'b0) begin
      n_errors++;
      $display("FAIL overrun_no_restart: busy %b %b, expected 0 0", busy_hist[LatA + 1],
               busy_hist[39]);
    end
  endtask

  task automatic test_back_to_back();
    vin_a   = 8'($urandom_range(0, 255));
    mode_a  = 0;
    tick_at = '{0, LatA};
    run_a(2 * LatA + 4);
    n_checks++;
    if (dv_cyc.size() != 2 || dv_cyc[0] != LatA || dv_cyc[1] != 2 * LatA) begin
      n_errors++;
      $display("FAIL b2b_dv: %0d pulses, expected 2 at %0d and %0d", dv_cyc.size(), LatA,
               2 * LatA);
    end
    n_checks++;
    if (ovr_cyc.size() != 0) begin
      n_errors++;
      $display("FAIL b2b_overrun: %0d pulses, expected 0", ovr_cyc.size());
    end
    n_checks++;
    if (dout_at_dv.size() != 2 || dout_at_dv[1] !== 16'(vin_a)) begin
      n_errors++;
      $display("FAIL b2b_data: got %h expected %h",
               (dout_at_dv.size() > 1) ? dout_at_dv[1] : 16'h0, vin_a);
    end
  endtask

  task automatic test_reset_mid();
    vin_a   = 8'h5A;
    mode_a  = 0;
    tick_at = '{0};
    run_a(10);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({dac_a, sh_a, busy_a, dout_a, dv_a, ovr_a} !== 20'h0) begin
      n_errors++;
      $display("FAIL reset_async: outputs %h, expected 0", {dac_a, sh_a, busy_a, dout_a, dv_a,
               ovr_a});
    end
    repeat (2) @(negedge clk_in);
    rst = 1'b0;
    tick_at.delete();
    run_a(LatA + 2);
    n_checks++;
    if (dv_cyc.size() != 0 || busy_hist[LatA] !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_abort: %0d dv pulses busy %b, expected 0 and 0", dv_cyc.size(),
               busy_hist[LatA]);
    end
    check_single("after_reset_3c", 'h3C, 0);
  endtask

  task automatic test_sweep();
    int res;
    for (int k = 0; k < 4; k++) begin
      vin_b = (k == 0) ? 4'h9 : 4'($urandom_range(0, 15));
      sar_ref(4, 1, int'(vin_b), 0, res);
      tick_at = '{0};
      run_b(LatB + 3);
      n_checks++;
      if (dv_cyc.size() != 1 || dv_cyc[0] != LatB || dout_at_dv[0] !== 16'(vin_b)) begin
        n_errors++;
        $display("FAIL sweep: %0d dv first at %0d data %h, expected 1 at %0d data %h",
                 dv_cyc.size(), (dv_cyc.size() > 0) ? dv_cyc[0] : -1,
                 (dout_at_dv.size() > 0) ? dout_at_dv[0] : 16'h0, LatB, vin_b);
      end
      n_checks++;
      if (cap.size() != exp_q.size() || (cap.size() > 0 && cap[cap.size() - 1] !== exp_q[exp_q.size() - 1])) begin
        n_errors++;
        $display("FAIL sweep_trials: %0d codes, expected %0d", cap.size(), exp_q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_conversion();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
